// File: rtl/fp_ops_pkg.sv
// Shared types and single-precision arithmetic helpers for the FP operator scheduler.
// Denormal inputs and results are flushed to zero; results are rounded to nearest-even.
package fp_ops_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_DIV  = 3'd3,
    OP_SQRT = 3'd4,
    OP_ABS  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  localparam int LAT_ADD_DEF  = 2;
  localparam int LAT_MUL_DEF  = 3;
  localparam int LAT_DIV_DEF  = 8;
  localparam int LAT_SQRT_DEF = 8;
  localparam int LAT_ABS_DEF  = 1;

  function automatic logic fp_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != '0);
  endfunction

  function automatic logic fp_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == '0);
  endfunction

  function automatic logic fp_zero(input logic [31:0] x);
    return x[30:23] == 8'h00;
  endfunction

  function automatic logic [5:0] lzc48(input logic [47:0] v);
    logic [5:0] n;
    n = 6'd48;
    for (int i = 0; i < 48; i++) if (v[i]) n = 6'(47 - i);
    return n;
  endfunction

  // m carries the value m/2^47 * 2^(e-127); normalise, round, pack.
  function automatic logic [31:0] fp_pack(input logic s, input logic signed [11:0] e,
                                          input logic [47:0] m);
    logic [47:0]        n;
    logic [24:0]        r;
    logic signed [11:0] ee;
    if (m == '0) return {s, 31'd0};
    n  = m << lzc48(m);
    ee = e - $signed({6'd0, lzc48(m)});
    r  = {1'b0, n[47:24]} + {24'd0, n[23] & ((|n[22:0]) | n[24])};
    if (r[24]) begin
      r  = r >> 1;
      ee = ee + 12'sd1;
    end
    if (ee >= 12'sd255) return {s, 8'hFF, 23'd0};
    if (ee <= 12'sd0) return {s, 31'd0};
    return {s, ee[7:0], r[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]        x, y;
    logic [7:0]         d;
    logic [47:0]        mx, my, sh, sum;
    logic signed [11:0] e;
    if (fp_nan(a) || fp_nan(b)) return FP_QNAN;
    if (fp_inf(a) && fp_inf(b)) return (a[31] == b[31]) ? a : FP_QNAN;
    if (fp_inf(a)) return a;
    if (fp_inf(b)) return b;
    if (fp_zero(a) && fp_zero(b)) return {a[31] & b[31], 31'd0};
    if (fp_zero(a)) return b;
    if (fp_zero(b)) return a;
    if (a[30:0] >= b[30:0]) begin
      x = a; y = b;
    end else begin
      x = b; y = a;
    end
    d  = x[30:23] - y[30:23];
    mx = {2'b01, x[22:0], 23'd0};
    my = {2'b01, y[22:0], 23'd0};
    // bits shifted out of the smaller operand survive as a sticky LSB
    if (d >= 8'd48) sh = 48'd1;
    else sh = (my >> d) | {47'd0, |(my & ~({48{1'b1}} << d))};
    sum = (x[31] ^ y[31]) ? mx - sh : mx + sh;
    e   = $signed({4'd0, x[30:23]}) + 12'sd1;
    if (sum == '0) return 32'd0;
    return fp_pack(x[31], e, sum);
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic               s;
    logic [47:0]        p;
    logic signed [11:0] e;
    s = a[31] ^ b[31];
    if (fp_nan(a) || fp_nan(b)) return FP_QNAN;
    if ((fp_inf(a) && fp_zero(b)) || (fp_zero(a) && fp_inf(b))) return FP_QNAN;
    if (fp_inf(a) || fp_inf(b)) return {s, 8'hFF, 23'd0};
    if (fp_zero(a) || fp_zero(b)) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = $signed({4'd0, a[30:23]}) + $signed({4'd0, b[30:23]}) - 12'sd126;
    return fp_pack(s, e, p);
  endfunction

  function automatic logic [31:0] fp_div(input logic [31:0] a, input logic [31:0] b);
    logic               s;
    logic [70:0]        num, den;
    logic [47:0]        q;
    logic signed [11:0] e;
    s = a[31] ^ b[31];
    if (fp_nan(a) || fp_nan(b)) return FP_QNAN;
    if ((fp_inf(a) && fp_inf(b)) || (fp_zero(a) && fp_zero(b))) return FP_QNAN;
    if (fp_inf(a) || fp_zero(b)) return {s, 8'hFF, 23'd0};
    if (fp_zero(a) || fp_inf(b)) return {s, 31'd0};
    num  = {1'b1, a[22:0], 47'd0};
    den  = {47'd0, 1'b1, b[22:0]};
    q    = 48'(num / den);
    q[0] = q[0] | (|(num % den));
    e    = $signed({4'd0, a[30:23]}) - $signed({4'd0, b[30:23]}) + 12'sd127;
    return fp_pack(s, e, q);
  endfunction

  function automatic logic [31:0] fp_sqrt(input logic [31:0] a);
    logic [95:0]        rad;
    logic [51:0]        rem, trial;
    logic [47:0]        root;
    logic signed [11:0] u;
    if (fp_nan(a)) return FP_QNAN;
    if (fp_zero(a)) return {a[31], 31'd0};
    if (a[31]) return FP_QNAN;
    if (fp_inf(a)) return a;
    u = $signed({4'd0, a[30:23]}) - 12'sd127;
    // odd exponents fold one factor of two into the radicand
    rad  = u[0] ? {1'b1, a[22:0], 72'd0} : {1'b0, 1'b1, a[22:0], 71'd0};
    rem  = '0;
    root = '0;
    for (int i = 47; i >= 0; i--) begin
      rem   = {rem[49:0], rad[2*i +: 2]};
      trial = {2'b00, root, 2'b01};
      if (rem >= trial) begin
        rem  = rem - trial;
        root = {root[46:0], 1'b1};
      end else begin
        root = {root[46:0], 1'b0};
      end
    end
    root[0] = root[0] | (|rem);
    return fp_pack(1'b0, (u >>> 1) + 12'sd127, root);
  endfunction

endpackage

// File: rtl/F_abs.sv
// Single-precision absolute value wrapper: clears the sign bit.
module F_abs (
  input  logic        aclk_i,
  input  logic [31:0] a_i,
  output logic [31:0] res_o
);
  logic unused_clk;
  assign unused_clk = aclk_i;
  assign res_o      = {1'b0, a_i[30:0]};
endmodule

// File: rtl/F_add.sv
// Single-precision adder wrapper (combinational).
module F_add
  import fp_ops_pkg::*;
(
  input  logic        aclk_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] res_o
);
  logic unused_clk;
  assign unused_clk = aclk_i;
  assign res_o      = fp_add(a_i, b_i);
endmodule

// File: rtl/F_div.sv
// Single-precision divider wrapper (A / B, combinational).
module F_div
  import fp_ops_pkg::*;
(
  input  logic        aclk_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] res_o
);
  logic unused_clk;
  assign unused_clk = aclk_i;
  assign res_o      = fp_div(a_i, b_i);
endmodule

// File: rtl/F_mult.sv
// Single-precision multiplier wrapper (combinational).
module F_mult
  import fp_ops_pkg::*;
(
  input  logic        aclk_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] res_o
);
  logic unused_clk;
  assign unused_clk = aclk_i;
  assign res_o      = fp_mul(a_i, b_i);
endmodule

// File: rtl/F_sqrt.sv
// Single-precision square-root wrapper (combinational).
module F_sqrt
  import fp_ops_pkg::*;
(
  input  logic        aclk_i,
  input  logic [31:0] a_i,
  output logic [31:0] res_o
);
  logic unused_clk;
  assign unused_clk = aclk_i;
  assign res_o      = fp_sqrt(a_i);
endmodule

// File: rtl/F_sub.sv
// Single-precision subtractor wrapper (A - B, combinational).
module F_sub
  import fp_ops_pkg::*;
(
  input  logic        aclk_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] res_o
);
  logic unused_clk;
  assign unused_clk = aclk_i;
  assign res_o      = fp_add(a_i, {~b_i[31], b_i[30:0]});
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping to 0.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);
  localparam int PW = IW + 1;

  logic [PW-1:0] pos;
  logic          found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    pos       = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr_i} + PW'(k);
      if (pos >= PW'(N)) pos = pos - PW'(N);
      if (!found && req_i[pos[IW-1:0]]) begin
        found                 = 1'b1;
        gnt_o[pos[IW-1:0]]    = 1'b1;
        gnt_idx_o             = pos[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/fp_op_scheduler.sv
// Shares one set of FP operators among NREQ requesters: round-robin grant, one op in flight,
// per-opcode EXEC latency, registered tagged response held until accepted.
module fp_op_scheduler
  import fp_ops_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int LAT_ADD  = LAT_ADD_DEF,
  parameter int LAT_MUL  = LAT_MUL_DEF,
  parameter int LAT_DIV  = LAT_DIV_DEF,
  parameter int LAT_SQRT = LAT_SQRT_DEF,
  parameter int LAT_ABS  = LAT_ABS_DEF
) (
  input  logic                    aclk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [3*NREQ-1:0]       req_op,
  input  logic [32*NREQ-1:0]      req_a,
  input  logic [32*NREQ-1:0]      req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [31:0]             rsp_data,
  output logic                    rsp_err,
  output logic                    busy
);
  localparam int IW = $clog2(NREQ);

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d, id_q, id_d, rsp_id_q, rsp_id_d, gnt_idx;
  logic [NREQ-1:0] gnt;
  logic [2:0]      op_q, op_d;
  logic [31:0]     a_q, a_d, b_q, b_d, rsp_data_q, rsp_data_d, res;
  logic [31:0]     r_add, r_sub, r_mul, r_div, r_sqrt, r_abs;
  logic [7:0]      cnt_q, cnt_d;
  logic            rsp_err_q, rsp_err_d;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  F_add  u_add  (.aclk_i(aclk), .a_i(a_q), .b_i(b_q), .res_o(r_add));
  F_sub  u_sub  (.aclk_i(aclk), .a_i(a_q), .b_i(b_q), .res_o(r_sub));
  F_mult u_mul  (.aclk_i(aclk), .a_i(a_q), .b_i(b_q), .res_o(r_mul));
  F_div  u_div  (.aclk_i(aclk), .a_i(a_q), .b_i(b_q), .res_o(r_div));
  F_sqrt u_sqrt (.aclk_i(aclk), .a_i(a_q), .res_o(r_sqrt));
  F_abs  u_abs  (.aclk_i(aclk), .a_i(a_q), .res_o(r_abs));

  always_comb begin
    case (op_q)
      OP_ADD:  res = r_add;
      OP_SUB:  res = r_sub;
      OP_MUL:  res = r_mul;
      OP_DIV:  res = r_div;
      OP_SQRT: res = r_sqrt;
      OP_ABS:  res = r_abs;
      default: res = FP_QNAN;
    endcase
  end

  // Counter preload: the last EXEC cycle is the one where the count reaches zero.
  function automatic logic [7:0] lat_m1(input logic [2:0] op);
    case (op)
      OP_ADD, OP_SUB: return 8'(LAT_ADD - 1);
      OP_MUL:         return 8'(LAT_MUL - 1);
      OP_DIV:         return 8'(LAT_DIV - 1);
      OP_SQRT:        return 8'(LAT_SQRT - 1);
      default:        return 8'(LAT_ABS - 1);
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    req_ready  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (!reset && (|req_valid)) begin
          req_ready = gnt;
          id_d      = gnt_idx;
          op_d      = req_op[3*gnt_idx +: 3];
          a_d       = req_a[32*gnt_idx +: 32];
          b_d       = req_b[32*gnt_idx +: 32];
          cnt_d     = lat_m1(req_op[3*gnt_idx +: 3]);
          ptr_d     = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q == 8'd0) begin
          rsp_id_d   = id_q;
          rsp_data_d = res;
          rsp_err_d  = (op_q > 3'd5);
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      id_q       <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule
